spi_ctrl: RTL

Sequencing controller for the SPI master datapath: generates SCK from the system clock, issues the `load` and `shift` strobes to the 8-bit SPI shift register, and registers MISO into its serial input. Sits between the bus-side register interface (which supplies `start`, the divider and the polarity) and the shift register. Provides a busy/done handshake back to the bus side.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_if.sv | 43 ++++
 rtl/spi_clkdiv.sv | 33 +++
 rtl/spi_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master sequencing controller:
//   - spi_state_t : FSM state encoding (IDLE..DONE)
//   - SPI_BITS    : bits per transfer
//   - BCNT_W      : width of the bit counter (must hold 0..SPI_BITS)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BITS = 8;
    localparam int BCNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_LEAD  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } spi_state_t;

    // True for every state in which a transfer is in flight (LOAD..HOLD).
    function automatic logic in_transfer(spi_state_t s);
        return (s == ST_LOAD) || (s == ST_SETUP) || (s == ST_LEAD) ||
               (s == ST_TRAIL) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_if.sv
// -----------------------------------------------------------------------------
// spi_if
// Bundle between the bus-side registers / shift register and spi_ctrl.
// Signals:
//   start, div, cpol   : transfer request and its settings (bus side -> ctrl)
//   miso               : serial input from the pad (-> ctrl)
//   busy, done         : status handshake (ctrl -> bus side)
//   load, shift, miso_q: shift-register strobes and serial input (ctrl ->)
//   sck, cs_n          : pad outputs (ctrl ->)
//   dbg_state          : current FSM state, for observation only
// Handshake: start is a request level sampled only while the controller is
// idle; the cycle after it is accepted busy rises and stays high until the
// single-cycle done pulse, during which busy is low. start seen at any other
// time is ignored.
// Modports: master = controller view, slave = bus/shift-register view.
// -----------------------------------------------------------------------------
interface spi_if #(parameter int DIV_W = 8);
    import spi_pkg::*;

    logic             start;
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic             miso;
    logic             busy;
    logic             done;
    logic             load;
    logic             shift;
    logic             miso_q;
    logic             sck;
    logic             cs_n;
    spi_state_t       dbg_state;

    modport master (
        input  start, div, cpol, miso,
        output busy, done, load, shift, miso_q, sck, cs_n, dbg_state
    );

    modport slave (
        output start, div, cpol, miso,
        input  busy, done, load, shift, miso_q, sck, cs_n, dbg_state
    );

endinterface

// File: rtl/spi_clkdiv.sv
// -----------------------------------------------------------------------------
// spi_clkdiv
// Phase counter for SCK generation. Counts 0..i_div and wraps; o_tick is high
// on the last cycle of each phase, so every phase lasts i_div+1 clk cycles.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear (holds the counter at 0)
//   i_div    : terminal count
//   o_tick   : last cycle of the current phase
// -----------------------------------------------------------------------------
module spi_clkdiv #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_div);

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ctrl
// Sequencing controller for the SPI master datapath (CPHA=0, mode 0/2).
// Generates SCK, the load/shift strobes for the 8-bit shift register, and
// registers MISO into the shift register's serial input.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_if.master (start/div/cpol/miso in; busy/done/load/shift/
//              miso_q/sck/cs_n/dbg_state out)
// Option macro SPI_CS_EN: when defined, cs_n is driven low from LOAD through
// HOLD; otherwise cs_n is held at 1 and chip select is managed externally.
// All outputs are registered: each is computed from the next state and
// flopped, so it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module spi_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic  clk,
    input  logic  rst,
    spi_if.master bus
);

    spi_state_t       r_state;
    spi_state_t       w_next;
    logic [DIV_W-1:0] r_div;
    logic             r_cpol;
    logic [BCNT_W-1:0] r_bcnt;

    logic r_busy, r_done, r_load, r_shift, r_miso_q, r_sck, r_cs_n;
    logic w_busy_d, w_done_d, w_load_d, w_shift_d, w_sck_d, w_cs_n_d;
    logic w_tick, w_clr, w_cpol, w_accept, w_shift_ev;

    // The phase counter only runs in the timed states.
    assign w_clr    = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign w_accept = (r_state == ST_IDLE) && bus.start;

    spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_div  (r_div),
        .o_tick (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SETUP;
            ST_SETUP: if (w_tick) w_next = ST_LEAD;
            ST_LEAD:  if (w_tick) w_next = ST_TRAIL;
            ST_TRAIL: if (w_tick) w_next = (r_bcnt == BCNT_W'(SPI_BITS)) ? ST_HOLD : ST_LEAD;
            ST_HOLD:  if (w_tick) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output logic (values for the next cycle)
    always_comb begin
        // In IDLE the live cpol is used so SCK tracks it and the value
        // latched at start is already in effect during LOAD.
        w_cpol     = (r_state == ST_IDLE) ? bus.cpol : r_cpol;
        w_shift_ev = (r_state == ST_LEAD) && (w_next == ST_TRAIL);
        w_busy_d   = in_transfer(w_next);
        w_done_d   = (w_next == ST_DONE);
        w_load_d   = (w_next == ST_LOAD);
        w_shift_d  = w_shift_ev;
        w_sck_d    = (w_next == ST_LEAD) ? ~w_cpol : w_cpol;
`ifdef SPI_CS_EN
        w_cs_n_d   = ~in_transfer(w_next);
`else
        w_cs_n_d   = 1'b1;
`endif
    end

    // Output, settings, bit counter and MISO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_load   <= 1'b0;
            r_shift  <= 1'b0;
            r_miso_q <= 1'b0;
            r_sck    <= 1'b0;
            r_cs_n   <= 1'b1;
            r_div    <= '0;
            r_cpol   <= 1'b0;
            r_bcnt   <= '0;
        end else begin
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_load  <= w_load_d;
            r_shift <= w_shift_d;
            r_sck   <= w_sck_d;
            r_cs_n  <= w_cs_n_d;
            if (w_accept) begin
                r_div  <= bus.div;
                r_cpol <= bus.cpol;
            end
            // Counter advances together with the shift strobe, so during
            // TRAIL k it already reads k and the end-of-phase test is direct.
            if (r_state == ST_LOAD) begin
                r_bcnt <= '0;
            end else if (w_shift_ev && (r_bcnt != BCNT_W'(SPI_BITS))) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
            // Capture on the last LEAD cycle; the shift strobe follows next.
            if ((r_state == ST_LEAD) && w_tick) begin
                r_miso_q <= bus.miso;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.load      = r_load;
    assign bus.shift     = r_shift;
    assign bus.miso_q    = r_miso_q;
    assign bus.sck       = r_sck;
    assign bus.cs_n      = r_cs_n;
    assign bus.dbg_state = r_state;

endmodule
